// File: rtl/regfile_dump.sv
// Register-file dump engine: streams r[FIRST..LAST] out over a valid/ready port, two cycles per word.
// Optional `REGFILE_DUMP_CLEAR_EN adds a CLEAR pass that zeroes the dumped range after the last word.
module regfile_dump (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [4:0]  FIRST,
  input  logic [4:0]  LAST,
  output logic [4:0]  A1,
  input  logic [31:0] RD1,
  output logic [31:0] DOUT,
  output logic [4:0]  DIDX,
  output logic        DVALID,
  input  logic        DREADY,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        BUSY,
  output logic        DONE
);

`ifdef REGFILE_DUMP_CLEAR_EN
  typedef enum logic [2:0] {IDLE, READ, HOLD, CLEAR, FINISH} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, HOLD, FINISH} state_t;
`endif

  state_t      state;
  logic [4:0]  index;
  logic [4:0]  last_q;
  logic [31:0] dout_q;
  logic [4:0]  didx_q;
  logic        dvalid_q;
  logic        busy_q;
  logic        done_q;

`ifdef REGFILE_DUMP_CLEAR_EN
  logic [4:0]  first_q;
  logic        we3_q;
  logic [4:0]  a3_q;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      index    <= '0;
      last_q   <= '0;
      dout_q   <= '0;
      didx_q   <= '0;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef REGFILE_DUMP_CLEAR_EN
      first_q  <= '0;
      we3_q    <= 1'b0;
      a3_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            index  <= FIRST;
            last_q <= LAST;
            busy_q <= 1'b1;
`ifdef REGFILE_DUMP_CLEAR_EN
            first_q <= FIRST;
`endif
            if (FIRST <= LAST) begin
              state <= READ;
            end else begin
              state  <= FINISH;
              done_q <= 1'b1;
            end
          end
        end
        READ: begin
          dout_q   <= RD1;
          didx_q   <= index;
          dvalid_q <= 1'b1;
          state    <= HOLD;
        end
        HOLD: begin
          if (DREADY) begin
            dvalid_q <= 1'b0;
            // End test precedes the increment so LAST=31 never wraps to 0.
            if (index == last_q) begin
`ifdef REGFILE_DUMP_CLEAR_EN
              state <= CLEAR;
              we3_q <= 1'b1;
              a3_q  <= first_q;
`else
              state  <= FINISH;
              done_q <= 1'b1;
`endif
            end else begin
              index <= index + 5'd1;
              state <= READ;
            end
          end
        end
`ifdef REGFILE_DUMP_CLEAR_EN
        CLEAR: begin
          if (a3_q == last_q) begin
            we3_q  <= 1'b0;
            a3_q   <= '0;
            state  <= FINISH;
            done_q <= 1'b1;
          end else begin
            a3_q <= a3_q + 5'd1;
          end
        end
`endif
        FINISH: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign A1     = index;
  assign DOUT   = dout_q;
  assign DIDX   = didx_q;
  assign DVALID = dvalid_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign WD3    = '0;

`ifdef REGFILE_DUMP_CLEAR_EN
  assign WE3 = we3_q;
  assign A3  = a3_q;
`else
  assign WE3 = 1'b0;
  assign A3  = '0;
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized self-checking bench for regfile_dump; reference is the list of (index, r[index]) words a range should yield.
// Build with +define+REGFILE_DUMP_CLEAR_EN to also check the clear pass.
module tb_regfile_dump;

  logic        CLK = 1'b0;
  logic        RST, START, DVALID, DREADY, WE3, BUSY, DONE;
  logic [4:0]  FIRST, LAST, A1, DIDX, A3;
  logic [31:0] RD1, DOUT, WD3;

  logic [31:0] regs [32];
  assign RD1 = regs[A1];

  regfile_dump dut (
    .CLK(CLK), .RST(RST), .START(START), .FIRST(FIRST), .LAST(LAST),
    .A1(A1), .RD1(RD1), .DOUT(DOUT), .DIDX(DIDX), .DVALID(DVALID), .DREADY(DREADY),
    .WE3(WE3), .A3(A3), .WD3(WD3), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

`ifdef REGFILE_DUMP_CLEAR_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif

  int checks = 0;
  int errors = 0;

  // Observed during a dump
  int          got_idx [$];
  logic [31:0] got_val [$];
  int          got_a3 [$];
  int          n_done, first_valid, busy_cycles;
  bit          stable_ok, wd_ok, timed_out;

  // Reference model output
  int          exp_idx [$];
  logic [31:0] exp_val [$];
  int          exp_a3 [$];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [82:0] outs();
    return {A1, DOUT, DIDX, DVALID, WE3, A3, WD3, BUSY, DONE};
  endfunction

  // A range yields r[f..l] in order, or nothing when f > l; the clear pass revisits the same indices.
  function automatic void build_expected(input int f, input int l);
    exp_idx.delete(); exp_val.delete(); exp_a3.delete();
    for (int i = f; i <= l; i++) begin
      exp_idx.push_back(i);
      exp_val.push_back(regs[i]);
      if (CLR != 0) exp_a3.push_back(i);
    end
  endfunction

  function automatic int word_errors();
    int bad = 0;
    if (got_idx.size() != exp_idx.size()) bad++;
    foreach (exp_idx[k])
      if (k >= got_idx.size() || got_idx[k] != exp_idx[k] || got_val[k] !== exp_val[k]) bad++;
    return bad;
  endfunction

  function automatic int clear_errors();
    int bad = 0;
    if (got_a3.size() != exp_a3.size()) bad++;
    foreach (exp_a3[k])
      if (k >= got_a3.size() || got_a3[k] != exp_a3[k]) bad++;
    return bad;
  endfunction

  // Issue START and collect everything the DUT does until it goes idle; optionally fire a stray START mid-dump.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int ready_pct, input int inject_at);
    logic        prev_v, prev_acc;
    logic [31:0] prev_d;
    logic [4:0]  prev_i;
    got_idx.delete(); got_val.delete(); got_a3.delete();
    n_done = 0; first_valid = -1; busy_cycles = 0;
    stable_ok = 1; wd_ok = 1; timed_out = 1;
    prev_v = 0; prev_acc = 0; prev_d = '0; prev_i = '0;
    START = 1'b1; FIRST = f; LAST = l; DREADY = 1'b0;
    tick();
    for (int n = 1; n < 2000; n++) begin
      START = (n == inject_at);
      FIRST = (n == inject_at) ? (f ^ 5'h10) : 5'($urandom);
      LAST  = 5'($urandom);
      if (DVALID && first_valid < 0) first_valid = n;
      if (DVALID && prev_v && !prev_acc && (DOUT !== prev_d || DIDX !== prev_i)) stable_ok = 0;
      if (BUSY) busy_cycles++;
      if (DONE) n_done++;
      if (WE3) begin
        got_a3.push_back(int'(A3));
        if (WD3 !== 32'd0) wd_ok = 0;
      end
      if (!BUSY) begin
        timed_out = 0;
        break;
      end
      DREADY   = ($urandom_range(99) < ready_pct);
      prev_acc = DVALID && DREADY;
      prev_v   = DVALID; prev_d = DOUT; prev_i = DIDX;
      if (prev_acc) begin
        got_idx.push_back(int'(DIDX));
        got_val.push_back(DOUT);
      end
      tick();
    end
    START = 1'b0; DREADY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; FIRST = '0; LAST = '0; DREADY = 1'b0;
    tick(); tick();
    checks++;
    if (outs() !== 83'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs()); end
    RST = 1'b0;
    tick(); tick();
    checks++;
    if (outs() !== 83'd0) begin errors++; $display("FAIL idle_after_reset got %h want 0", outs()); end
  endtask

  task automatic test_full_dump();
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h1111_1111;
    build_expected(0, 31);
    run_dump(5'd0, 5'd31, 100, -1);
    checks++;
    if (timed_out) begin errors++; $display("FAIL full_timeout got busy want idle"); end
    checks++;
    if (word_errors() != 0) begin errors++; $display("FAIL full_words got %0d words (%0d bad) want 32", got_idx.size(), word_errors()); end
    checks++;
    if (first_valid != 2) begin errors++; $display("FAIL full_latency got %0d want 2", first_valid); end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL full_done got %0d want 1", n_done); end
    checks++;
    if (busy_cycles != 65 + CLR * 32) begin errors++; $display("FAIL full_busy got %0d want %0d", busy_cycles, 65 + CLR * 32); end
    checks++;
    if (clear_errors() != 0 || !wd_ok) begin errors++; $display("FAIL full_clear got %0d writes want %0d", got_a3.size(), exp_a3.size()); end
    tick(); tick();
    checks++;
    if (BUSY !== 1'b0 || DVALID !== 1'b0) begin errors++; $display("FAIL full_no_wrap got busy=%b valid=%b want 0 0", BUSY, DVALID); end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    int seen = 0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    START = 1'b1; FIRST = 5'd4; LAST = 5'd5; DREADY = 1'b0;
    tick();
    START = 1'b0; FIRST = 5'd20; LAST = 5'd9;
    tick();
    for (int c = 0; c < 5; c++) begin
      if (DVALID !== 1'b1 || DOUT !== regs[4] || DIDX !== 5'd4) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles want 0 (dout %h want %h)", bad, DOUT, regs[4]); end
    checks++;
    if (DVALID !== 1'b1 || DOUT !== regs[4]) begin errors++; $display("FAIL bp_still_valid got %b %h want 1 %h", DVALID, DOUT, regs[4]); end
    DREADY = 1'b1;
    tick();
    checks++;
    if (DVALID !== 1'b0) begin errors++; $display("FAIL bp_drop got %b want 0", DVALID); end
    tick();
    checks++;
    if (DVALID !== 1'b1 || DOUT !== regs[5] || DIDX !== 5'd5) begin
      errors++; $display("FAIL bp_second got %b %h %0d want 1 %h 5", DVALID, DOUT, DIDX, regs[5]);
    end
    for (int c = 0; c < 10 && seen == 0; c++) begin
      tick();
      if (DONE) seen = 1;
    end
    checks++;
    if (seen != 1) begin errors++; $display("FAIL bp_done got no pulse want 1"); end
    DREADY = 1'b0;
    tick(); tick();
  endtask

  task automatic test_empty();
    build_expected(7, 3);
    run_dump(5'd7, 5'd3, 100, -1);
    checks++;
    if (got_idx.size() != 0 || first_valid != -1) begin errors++; $display("FAIL empty_words got %0d want 0", got_idx.size()); end
    checks++;
    if (n_done != 1 || busy_cycles != 1 || timed_out) begin
      errors++; $display("FAIL empty_done got done=%0d busy=%0d want 1 1", n_done, busy_cycles);
    end
  endtask

  task automatic test_start_busy();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    build_expected(10, 14);
    run_dump(5'd10, 5'd14, 100, 3);
    checks++;
    if (word_errors() != 0 || timed_out) begin errors++; $display("FAIL busy_start_words got %0d words want 5", got_idx.size()); end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL busy_start_done got %0d want 1", n_done); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    START = 1'b1; FIRST = 5'd2; LAST = 5'd6; DREADY = 1'b0;
    tick();
    START = 1'b0;
    tick();
    checks++;
    if (DVALID !== 1'b1 || DIDX !== 5'd2) begin errors++; $display("FAIL mid_pre got %b %0d want 1 2", DVALID, DIDX); end
    RST = 1'b1;
    #1;
    checks++;
    if (outs() !== 83'd0) begin errors++; $display("FAIL mid_reset_outputs got %h want 0", outs()); end
    tick();
    RST = 1'b0;
    DREADY = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (DONE || BUSY || DVALID) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mid_no_resume got %0d active cycles want 0", bad); end
    DREADY = 1'b0;
    build_expected(2, 6);
    run_dump(5'd2, 5'd6, 60, -1);
    checks++;
    if (word_errors() != 0 || n_done != 1 || timed_out) begin
      errors++; $display("FAIL mid_redump got %0d words done=%0d want 5 1", got_idx.size(), n_done);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    build_expected(1, 3);
    run_dump(5'd1, 5'd3, 100, -1);
    checks++;
    if (clear_errors() != 0 || !wd_ok) begin errors++; $display("FAIL clear_writes got %0d writes want %0d", got_a3.size(), exp_a3.size()); end
    checks++;
    if (word_errors() != 0 || n_done != 1) begin errors++; $display("FAIL clear_dump got %0d words done=%0d want 3 1", got_idx.size(), n_done); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      logic [4:0] f, l;
      int pct;
      f = 5'($urandom); l = 5'($urandom); pct = $urandom_range(100, 20);
      if (it == 0) begin f = 5'd31; l = 5'd31; end
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      build_expected(int'(f), int'(l));
      run_dump(f, l, pct, -1);
      checks++;
      if (word_errors() != 0 || timed_out) begin
        errors++; $display("FAIL rand_words f=%0d l=%0d got %0d words want %0d", f, l, got_idx.size(), exp_idx.size());
      end
      checks++;
      if (n_done != 1 || !stable_ok || clear_errors() != 0 || !wd_ok) begin
        errors++; $display("FAIL rand_ctrl f=%0d l=%0d got done=%0d stable=%0d want 1 1", f, l, n_done, stable_ok);
      end
      if (exp_idx.size() > 0) begin
        checks++;
        if (first_valid != 2) begin errors++; $display("FAIL rand_latency got %0d want 2", first_valid); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_empty();
    test_start_busy();
    test_reset_mid();
    test_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have ports: CLK  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: RST  input  1  reset; asynchronous, active-high.
REQ-003 SHALL have ports: START  input  1  one-cycle request to begin a dump.
REQ-004 SHALL have ports: FIRST  input  5 and LAST  input  5  inclusive register index range, sampled only with START.
REQ-005 SHALL have ports: A1  output  5  register file read address; RD1  input  32  register file read data.
REQ-006 SHALL have ports: DOUT  output  32  dumped value; DIDX  output  5  index of DOUT; DVALID  output  1; DREADY  input  1.
REQ-007 SHALL have ports: WE3  output  1, A3  output  5, WD3  output  32  register file write port.
REQ-008 SHALL have ports: BUSY  output  1  dump in progress; DONE  output  1  one-cycle completion pulse.

Function
REQ-009 SHALL implement states IDLE, READ, HOLD, CLEAR, FINISH.
REQ-010 IDLE: BUSY=0; on START=1, latch FIRST/LAST, set index=FIRST; if FIRST<=LAST go READ, else go FINISH without emitting data.
REQ-011 A1 SHALL equal the current index register in all states; RD1 is treated as a combinational read of A1.
REQ-012 READ: one cycle; at its closing edge DOUT<=RD1, DIDX<=index, DVALID<=1, go HOLD.
REQ-013 HOLD: DVALID=1, DOUT/DIDX stable until a rising edge with DREADY=1.
REQ-014 HOLD with DREADY=1: if index==LAST, go CLEAR (macro defined) or FINISH; else index+1, go READ.
REQ-015 The end test SHALL compare index==LAST before incrementing; LAST=31 SHALL terminate without 5-bit wrap to 0.
REQ-016 DVALID SHALL drop in the cycle after the accepting edge; latency START edge -> DVALID high is 2 cycles; sustained rate 1 word per 2 cycles with DREADY held high.
REQ-017 FINISH: DONE=1 for exactly one cycle, BUSY=1, then IDLE.
REQ-018 BUSY SHALL be 1 in READ, HOLD, CLEAR, FINISH; START while BUSY=1 SHALL be ignored.
REQ-019 Outside CLEAR, WE3=0, A3=0, WD3=0.
REQ-020 FIRST/LAST changes after the START cycle SHALL not affect the running dump.

Reset
REQ-021 RST=1 SHALL immediately force state IDLE, index=0, and A1, DOUT, DIDX, DVALID, WE3, A3, WD3, BUSY, DONE all 0.
REQ-022 RST asserted mid-dump SHALL abort it with no DONE pulse; the next dump requires a new START.

Configuration
REQ-023 Macro REGFILE_DUMP_CLEAR_EN SHALL, when defined, compile in the CLEAR state.
REQ-024 With macro: CLEAR writes WD3=0 with WE3=1, A3 stepping FIRST..LAST one register per cycle, then FINISH; index 0 written like any other.
REQ-025 Without macro: no CLEAR state; WE3, A3, WD3 tied 0; HOLD on last word goes directly to FINISH.

Verification
REQ-026 Reset mid-dump: RST pulse during HOLD -> all outputs 0 next sample, no DONE, next START dumps normally.
REQ-027 Full dump: regs r[i]=i*0x11111111 (r0=0), START FIRST=0 LAST=31, DREADY=1 -> 32 words in order, DIDX 0..31, DVALID first high 2 cycles after START, DONE once after word 31, no wrap.
REQ-028 Backpressure: FIRST=4 LAST=5, DREADY=0 for 5 cycles -> DOUT=r4, DIDX=4 held stable; DREADY=1 -> r5 follows, then DONE.
REQ-029 Empty range: FIRST=7 LAST=3 -> no DVALID, DONE pulses one cycle after START edge, BUSY high one cycle.
REQ-030 START while BUSY: second START mid-dump with different FIRST -> ignored, original sequence completes unchanged.
REQ-031 With REGFILE_DUMP_CLEAR_EN: FIRST=1 LAST=3 after dump -> WE3=1 three cycles, A3=1,2,3, WD3=0, then DONE; without macro WE3 never asserts.
